// File: rtl/core_bus_arbiter.sv
// Purpose : merges the core's ibus fetch and dbus load/store streams onto one
//           shared memory port, one outstanding transaction at a time.
// Latency : grant in IDLE, m_valid the next cycle; 2 cycles minimum per
//           transaction, 3 typical; responses are combinational from m_*_ok.
// Backpressure: m_addr_ok stalls the address phase and m_data_ok the data
//           phase; a core request is simply left pending until it is granted.
//
// Ports:
//   clk, resetn                   clock, asynchronous active-low reset
//   ireq_* / iresp_*              fetch request in, fetch response out
//   dreq_* / dresp_*              data request in, data response out
//   m_valid/m_addr/m_strobe/m_wdata   shared-port request out (registered)
//   m_addr_ok/m_data_ok/m_rdata       shared-port handshake and read data in

module core_bus_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        resetn,
   // fetch bus
   input  logic        ireq_valid,
   input  logic [31:0] ireq_addr,
   output logic        iresp_addr_ok,
   output logic        iresp_data_ok,
   output logic [31:0] iresp_data,
   // data bus
   input  logic        dreq_valid,
   input  logic [31:0] dreq_addr,
   input  logic [3:0]  dreq_strobe,
   input  logic [31:0] dreq_data,
   output logic        dresp_addr_ok,
   output logic        dresp_data_ok,
   output logic [31:0] dresp_data,
   // shared memory port
   output logic        m_valid,
   output logic [31:0] m_addr,
   output logic [3:0]  m_strobe,
   output logic [31:0] m_wdata,
   input  logic        m_addr_ok,
   input  logic        m_data_ok,
   input  logic [31:0] m_rdata
);

   localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT   = CW'(STARVE_LIMIT);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      I_ADDR = 3'd1,
      I_DATA = 3'd2,
      D_ADDR = 3'd3,
      D_DATA = 3'd4
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_starve_cnt;
   logic [31:0]   r_addr;
   logic [3:0]    r_strobe;
   logic [31:0]   r_wdata;
   logic          w_grant_d;
   logic          w_grant_i;

   // Data wins unless a fetch is waiting and has already been passed over
   // STARVE_LIMIT times in a row.
   always_comb begin
      w_grant_d = 1'b0;
      w_grant_i = 1'b0;
      if (r_state == IDLE) begin
         if (dreq_valid && (!ireq_valid || (r_starve_cnt < LIMIT))) begin
            w_grant_d = 1'b1;
         end else if (ireq_valid) begin
            w_grant_i = 1'b1;
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic. A data_ok alongside addr_ok in the address phase
   // finishes the transaction outright; a data_ok without addr_ok there is
   // not meaningful and is dropped.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_grant_d) begin
               w_state_nxt = D_ADDR;
            end else if (w_grant_i) begin
               w_state_nxt = I_ADDR;
            end
         end
         I_ADDR: begin
            if (m_addr_ok) begin
               w_state_nxt = m_data_ok ? IDLE : I_DATA;
            end
         end
         I_DATA: begin
            if (m_data_ok) begin
               w_state_nxt = IDLE;
            end
         end
         D_ADDR: begin
            if (m_addr_ok) begin
               w_state_nxt = m_data_ok ? IDLE : D_DATA;
            end
         end
         D_DATA: begin
            if (m_data_ok) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Output logic: m_* comes only from state and the request registers so
   // the memory side never sees core inputs change under it.
   always_comb begin
      m_valid       = (r_state == I_ADDR) || (r_state == D_ADDR);
      m_addr        = r_addr;
      m_strobe      = r_strobe;
      m_wdata       = r_wdata;
      iresp_addr_ok = 1'b0;
      iresp_data_ok = 1'b0;
      iresp_data    = 32'h0;
      dresp_addr_ok = 1'b0;
      dresp_data_ok = 1'b0;
      dresp_data    = 32'h0;
      case (r_state)
         I_ADDR: begin
            iresp_addr_ok = m_addr_ok;
            iresp_data_ok = m_addr_ok && m_data_ok;
         end
         I_DATA: iresp_data_ok = m_data_ok;
         D_ADDR: begin
            dresp_addr_ok = m_addr_ok;
            dresp_data_ok = m_addr_ok && m_data_ok;
         end
         D_DATA: dresp_data_ok = m_data_ok;
         default: ;
      endcase
      if (iresp_data_ok) begin
         iresp_data = m_rdata;
      end
      if (dresp_data_ok) begin
         dresp_data = m_rdata;
      end
   end

   // Request registers and starvation counter, updated only on a grant.
   // The counter only tracks D grants that actually made a fetch wait.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_addr       <= 32'h0;
         r_strobe     <= 4'h0;
         r_wdata      <= 32'h0;
         r_starve_cnt <= '0;
      end else if (w_grant_d) begin
         r_addr   <= dreq_addr;
         r_strobe <= dreq_strobe;
         r_wdata  <= dreq_data;
         if (ireq_valid && (r_starve_cnt < LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + CNT_ONE;
         end
      end else if (w_grant_i) begin
         r_addr       <= ireq_addr;
         r_strobe     <= 4'h0;
         r_wdata      <= 32'h0;
         r_starve_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Purpose : self-checking bench for core_bus_arbiter: cycle vector table,
//           hand sequences for starvation and reset, then random traffic.
// Latency : inputs change just after the falling edge, outputs sampled 1 ns later.
// Backpressure: the bench plays both the core (holds requests until data_ok)
//           and the memory (random addr_ok/data_ok).

module tb_core_bus_arbiter;

   localparam int LIMIT = 4;

   logic        clk;
   logic        resetn;
   logic        ireq_valid;
   logic [31:0] ireq_addr;
   logic        iresp_addr_ok;
   logic        iresp_data_ok;
   logic [31:0] iresp_data;
   logic        dreq_valid;
   logic [31:0] dreq_addr;
   logic [3:0]  dreq_strobe;
   logic [31:0] dreq_data;
   logic        dresp_addr_ok;
   logic        dresp_data_ok;
   logic [31:0] dresp_data;
   logic        m_valid;
   logic [31:0] m_addr;
   logic [3:0]  m_strobe;
   logic [31:0] m_wdata;
   logic        m_addr_ok;
   logic        m_data_ok;
   logic [31:0] m_rdata;

   int checks   = 0;
   int failures = 0;

   core_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .ireq_valid    (ireq_valid),
      .ireq_addr     (ireq_addr),
      .iresp_addr_ok (iresp_addr_ok),
      .iresp_data_ok (iresp_data_ok),
      .iresp_data    (iresp_data),
      .dreq_valid    (dreq_valid),
      .dreq_addr     (dreq_addr),
      .dreq_strobe   (dreq_strobe),
      .dreq_data     (dreq_data),
      .dresp_addr_ok (dresp_addr_ok),
      .dresp_data_ok (dresp_data_ok),
      .dresp_data    (dresp_data),
      .m_valid       (m_valid),
      .m_addr        (m_addr),
      .m_strobe      (m_strobe),
      .m_wdata       (m_wdata),
      .m_addr_ok     (m_addr_ok),
      .m_data_ok     (m_data_ok),
      .m_rdata       (m_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One cycle of stimulus plus the outputs it must produce in that cycle.
   typedef struct {
      logic        iv;
      logic [31:0] ia;
      logic        dv;
      logic [31:0] da;
      logic [3:0]  ds;
      logic [31:0] dd;
      logic        aok;
      logic        dok;
      logic [31:0] rd;
      logic        mv;
      logic [31:0] ma;
      logic [3:0]  ms;
      logic [31:0] mw;
      logic [1:0]  ir;    // {iresp_addr_ok, iresp_data_ok}
      logic [31:0] idat;
      logic [1:0]  dr;    // {dresp_addr_ok, dresp_data_ok}
      logic [31:0] ddat;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(
      input logic iv, input logic [31:0] ia,
      input logic dv, input logic [31:0] da, input logic [3:0] ds, input logic [31:0] dd,
      input logic aok, input logic dok, input logic [31:0] rd,
      input logic mv, input logic [31:0] ma, input logic [3:0] ms, input logic [31:0] mw,
      input logic [1:0] ir, input logic [31:0] idat, input logic [1:0] dr, input logic [31:0] ddat);
      vec_t v;
      v.iv = iv; v.ia = ia; v.dv = dv; v.da = da; v.ds = ds; v.dd = dd;
      v.aok = aok; v.dok = dok; v.rd = rd;
      v.mv = mv; v.ma = ma; v.ms = ms; v.mw = mw;
      v.ir = ir; v.idat = idat; v.dr = dr; v.ddat = ddat;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 40) begin
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
         end
      end
   endtask

   task automatic check_all(input string t, input logic emv, input logic [31:0] ema,
                            input logic [3:0] ems, input logic [31:0] emw,
                            input logic [1:0] eir, input logic [31:0] eid,
                            input logic [1:0] edr, input logic [31:0] edd);
      chk({t, "_m_valid"},  32'(m_valid), 32'(emv));
      chk({t, "_m_addr"},   m_addr, ema);
      chk({t, "_m_strobe"}, 32'(m_strobe), 32'(ems));
      chk({t, "_m_wdata"},  m_wdata, emw);
      chk({t, "_iresp_ok"}, 32'({iresp_addr_ok, iresp_data_ok}), 32'(eir));
      chk({t, "_iresp_data"}, iresp_data, eid);
      chk({t, "_dresp_ok"}, 32'({dresp_addr_ok, dresp_data_ok}), 32'(edr));
      chk({t, "_dresp_data"}, dresp_data, edd);
   endtask

   task automatic zero_inputs();
      ireq_valid = 1'b0; ireq_addr = 32'h0;
      dreq_valid = 1'b0; dreq_addr = 32'h0; dreq_strobe = 4'h0; dreq_data = 32'h0;
      m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 32'h0;
   endtask

   // Watchdog: the bench is cycle-bounded, this only catches a stuck simulator.
   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        exp_is_i [10];
      int          ntx;
      int          gap;
      // reference model state (transaction level)
      int          owner;     // 0 none, 1 fetch, 2 data
      bit          adone;
      int          starve;
      bit          ip, dp;
      logic [31:0] qa, qw;
      logic [3:0]  qs;
      logic        e_mv, afire, dfire, fi, fd;

      // ---------------- reset state, before any clock edge ----------------
      resetn = 1'b0;
      zero_inputs();
      #1;
      check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;

      // ---------------- vector table ----------------
      // single fetch: addr_ok one cycle after m_valid, data_ok one more later
      add(1,32'hBFC0_0000, 0,0,0,0, 0,0,0,            0,32'h0,0,0, 2'b00,0,2'b00,0);
      add(1,32'hBFC0_0000, 0,0,0,0, 0,0,0,            1,32'hBFC0_0000,0,0, 2'b00,0,2'b00,0);
      add(1,32'hBFC0_0000, 0,0,0,0, 1,0,0,            1,32'hBFC0_0000,0,0, 2'b10,0,2'b00,0);
      add(1,32'hBFC0_0000, 0,0,0,0, 0,1,32'h2408_0001, 0,32'hBFC0_0000,0,0, 2'b01,32'h2408_0001,2'b00,0);
      // stray addr_ok/data_ok in IDLE are ignored
      add(0,0, 0,0,0,0, 1,1,32'hFFFF_FFFF,            0,32'hBFC0_0000,0,0, 2'b00,0,2'b00,0);
      // simultaneous: store first, then fetch after one idle cycle
      add(1,32'hBFC0_0004, 1,32'h8000_0010,4'hF,32'hDEAD_BEEF, 0,0,0,
          0,32'hBFC0_0000,0,0, 2'b00,0,2'b00,0);
      add(1,32'hBFC0_0004, 1,32'h8000_0010,4'hF,32'hDEAD_BEEF, 1,0,0,
          1,32'h8000_0010,4'hF,32'hDEAD_BEEF, 2'b00,0,2'b10,0);
      add(1,32'hBFC0_0004, 1,32'h8000_0010,4'hF,32'hDEAD_BEEF, 0,1,32'h1234_5678,
          0,32'h8000_0010,4'hF,32'hDEAD_BEEF, 2'b00,0,2'b01,32'h1234_5678);
      add(1,32'hBFC0_0004, 0,0,0,0, 0,0,0,
          0,32'h8000_0010,4'hF,32'hDEAD_BEEF, 2'b00,0,2'b00,0);
      // fetch issued with fast memory (addr_ok+data_ok together)
      add(1,32'hBFC0_0004, 0,0,0,0, 1,1,32'h2408_0002,
          1,32'hBFC0_0004,0,0, 2'b11,32'h2408_0002,2'b00,0);
      // fast load: 2-cycle transaction
      add(0,0, 1,32'h8000_0020,0,0, 0,0,0,            0,32'hBFC0_0004,0,0, 2'b00,0,2'b00,0);
      add(0,0, 1,32'h8000_0020,0,0, 1,1,32'hCAFE_F00D,
          1,32'h8000_0020,0,0, 2'b00,0,2'b11,32'hCAFE_F00D);
      // data_ok without addr_ok in D_ADDR is ignored; stalled data phase
      add(0,0, 1,32'h8000_0030,4'h3,32'h0000_AAAA, 0,0,0,
          0,32'h8000_0020,0,0, 2'b00,0,2'b00,0);
      add(0,0, 1,32'h8000_0030,4'h3,32'h0000_AAAA, 0,1,32'h0000_1111,
          1,32'h8000_0030,4'h3,32'h0000_AAAA, 2'b00,0,2'b00,0);
      add(0,0, 1,32'h8000_0030,4'h3,32'h0000_AAAA, 1,0,0,
          1,32'h8000_0030,4'h3,32'h0000_AAAA, 2'b00,0,2'b10,0);
      add(0,0, 1,32'h8000_0030,4'h3,32'h0000_AAAA, 0,0,0,
          0,32'h8000_0030,4'h3,32'h0000_AAAA, 2'b00,0,2'b00,0);
      add(0,0, 1,32'h8000_0030,4'h3,32'h0000_AAAA, 0,1,32'h55AA_55AA,
          0,32'h8000_0030,4'h3,32'h0000_AAAA, 2'b00,0,2'b01,32'h55AA_55AA);
      add(0,0, 0,0,0,0, 0,0,0,                        0,32'h8000_0030,4'h3,32'h0000_AAAA, 2'b00,0,2'b00,0);

      foreach (vecs[k]) begin
         @(negedge clk);
         ireq_valid = vecs[k].iv; ireq_addr = vecs[k].ia;
         dreq_valid = vecs[k].dv; dreq_addr = vecs[k].da;
         dreq_strobe = vecs[k].ds; dreq_data = vecs[k].dd;
         m_addr_ok = vecs[k].aok; m_data_ok = vecs[k].dok; m_rdata = vecs[k].rd;
         #1;
         check_all($sformatf("vec%0d", k), vecs[k].mv, vecs[k].ma, vecs[k].ms, vecs[k].mw,
                   vecs[k].ir, vecs[k].idat, vecs[k].dr, vecs[k].ddat);
      end

      // ---------------- starvation: D,D,D,D,I,D,D,D,D,I ----------------
      exp_is_i = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      ntx = 0;
      gap = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         ireq_valid = 1'b1; ireq_addr = 32'hBFC0_1000;
         dreq_valid = 1'b1; dreq_addr = 32'h8000_1000; dreq_strobe = 4'h0; dreq_data = 32'h0;
         m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h0000_0C0C;
         #1;
         if (m_valid) begin
            if (ntx < 10) begin
               chk($sformatf("starve_grant%0d_is_fetch", ntx), 32'(m_addr == 32'hBFC0_1000),
                   32'(exp_is_i[ntx]));
            end
            if (ntx > 0) begin
               chk("starve_idle_gap", 32'(gap), 32'd1);
            end
            ntx++;
            gap = 0;
         end else begin
            gap++;
         end
      end
      chk("starve_tx_count", 32'(ntx), 32'd10);

      // ---------------- reset in D_DATA ----------------
      // three fast D grants with a fetch waiting (count 1..3)
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         ireq_valid = 1'b1; ireq_addr = 32'hBFC0_2000;
         dreq_valid = 1'b1; dreq_addr = 32'h8000_2000; dreq_strobe = 4'h0; dreq_data = 32'h0;
         m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h0;
      end
      @(negedge clk);               // IDLE: fourth D grant, count reaches limit
      m_addr_ok = 1'b0; m_data_ok = 1'b0;
      #1;
      chk("rst_pre_idle_mvalid", 32'(m_valid), 32'd0);
      @(negedge clk);               // D_ADDR
      m_addr_ok = 1'b1;
      #1;
      check_all("rst_pre_daddr", 1, 32'h8000_2000, 0, 0, 2'b00, 0, 2'b10, 0);
      @(negedge clk);               // D_DATA
      m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h0000_0077;
      #1;
      check_all("rst_pre_ddata", 0, 32'h8000_2000, 0, 0, 2'b00, 0, 2'b01, 32'h0000_0077);
      #1;
      resetn = 1'b0;
      #1;
      check_all("rst_async_ddata", 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;                // stray oks in IDLE, both requests pending
      m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h0000_0099;
      #1;
      check_all("rst_release_idle", 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
      @(negedge clk);
      #1;
      // counter is back to 0, so data still wins over the waiting fetch
      check_all("rst_first_grant", 1, 32'h8000_2000, 0, 0, 2'b00, 0, 2'b11, 32'h0000_0099);
      @(negedge clk);
      dreq_valid = 1'b0;
      #1;
      chk("rst_gap_mvalid", 32'(m_valid), 32'd0);
      @(negedge clk);
      m_rdata = 32'h2408_0003;
      #1;
      check_all("rst_fetch_grant", 1, 32'hBFC0_2000, 0, 0, 2'b11, 32'h2408_0003, 2'b00, 0);

      // ---------------- reset in D_ADDR: m_valid falls without a clock ----------------
      @(negedge clk);
      ireq_valid = 1'b0; dreq_valid = 1'b1; dreq_addr = 32'h8000_3000;
      m_addr_ok = 1'b0; m_data_ok = 1'b0;
      @(negedge clk);
      #1;
      chk("rst2_daddr_mvalid", 32'(m_valid), 32'd1);
      #1;
      resetn = 1'b0;
      #1;
      check_all("rst2_async", 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
      zero_inputs();
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;

      // ---------------- random traffic against reference model ----------------
      owner = 0; adone = 1'b0; starve = 0; ip = 1'b0; dp = 1'b0;
      qa = 32'h0; qw = 32'h0; qs = 4'h0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (!ip && ($urandom_range(0, 2) == 0)) begin
            ip = 1'b1;
            ireq_addr = $urandom;
         end
         if (!dp && ($urandom_range(0, 2) == 0)) begin
            dp = 1'b1;
            dreq_addr   = $urandom;
            dreq_strobe = 4'($urandom_range(0, 15));
            dreq_data   = $urandom;
         end
         ireq_valid = ip;
         dreq_valid = dp;
         m_addr_ok  = ($urandom_range(0, 2) == 0);
         m_data_ok  = ($urandom_range(0, 1) == 1);
         m_rdata    = $urandom;
         #1;
         e_mv  = (owner != 0) && !adone;
         afire = e_mv && m_addr_ok;
         dfire = (owner != 0) && m_data_ok && (adone || m_addr_ok);
         fi    = (owner == 1);
         fd    = (owner == 2);
         check_all("rand", e_mv, qa, qs, qw,
                   {fi && afire, fi && dfire}, (fi && dfire) ? m_rdata : 32'h0,
                   {fd && afire, fd && dfire}, (fd && dfire) ? m_rdata : 32'h0);
         // advance the model to the next cycle
         if (owner == 0) begin
            if (dreq_valid && (!ireq_valid || starve < LIMIT)) begin
               owner = 2;
               qa = dreq_addr; qs = dreq_strobe; qw = dreq_data;
               if (ireq_valid) starve = (starve + 1 > LIMIT) ? LIMIT : starve + 1;
            end else if (ireq_valid) begin
               owner = 1;
               qa = ireq_addr; qs = 4'h0; qw = 32'h0;
               starve = 0;
            end
         end else if (dfire) begin
            if (owner == 1) ip = 1'b0;
            else dp = 1'b0;
            owner = 0;
            adone = 1'b0;
         end else if (afire) begin
            adone = 1'b1;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
